// File: rtl/cache_assoc.sv
// N-way set-associative write-back, write-allocate data cache.
// Optional CACHE_STATS_EN adds hit/miss/writeback counters.
module cache_assoc #(
  parameter int WAYS  = 2,
  parameter int SETS  = 32,
  parameter int WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 addr,
  input  logic                        re,
  input  logic                        we,
  input  logic [31:0]                 din,
  output logic [31:0]                 dout,
  output logic                        complete,
  output logic                        dram_re,
  output logic                        dram_we,
  output logic [30-$clog2(WORDS)-1:0] dram_addr,
  output logic [32*WORDS-1:0]         dram_din,
  input  logic [32*WORDS-1:0]         dram_dout,
  input  logic                        dram_complete
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                 hit_cnt,
  output logic [31:0]                 miss_cnt,
  output logic [31:0]                 wb_cnt
`endif
);

  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 30 - OFF_W - IDX_W;
  localparam int BLK_W  = 32 * WORDS;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int OFFS_W = (OFF_W > 0) ? OFF_W : 1;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t state_q, state_d;

  logic [SETS-1:0]  valid_q [WAYS];
  logic [SETS-1:0]  dirty_q [WAYS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [BLK_W-1:0] data_q  [WAYS][SETS];
  logic [WAY_W-1:0] ptr_q   [SETS];

  logic [WAY_W-1:0] vic_q;
  logic             used_inv_q;
  logic [31:0]      dout_q;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  idx;
  logic [OFFS_W-1:0] off;

  assign req_tag = addr[31:32-TAG_W];
  assign idx     = IDX_W'(addr >> (2 + OFF_W));
  assign off     = OFFS_W'((addr >> 2) & 32'(WORDS - 1));

  logic             hit, inv;
  logic [WAY_W-1:0] hit_way, inv_way, victim;

  // Descending scan so the lowest matching/invalid way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    inv     = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][idx] && tag_q[w][idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[w][idx]) begin
        inv     = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  logic [BLK_W-1:0] hit_blk;
  logic [31:0]      hit_word;
  logic             req, miss, vic_dirty;

  assign victim    = inv ? inv_way : ((WAYS > 1) ? ptr_q[idx] : '0);
  assign hit_blk   = data_q[hit_way][idx];
  assign hit_word  = hit_blk[{off, 5'b0} +: 32];
  assign req       = re | we;
  assign complete  = (state_q == IDLE) && req && hit;
  assign miss      = (state_q == IDLE) && req && !hit;
  assign vic_dirty = valid_q[victim][idx] && dirty_q[victim][idx];
  assign dout      = (complete && re) ? hit_word : dout_q;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss) state_d = vic_dirty ? WB : FILL;
      WB:      if (dram_complete) state_d = FILL;
      FILL:    if (dram_complete) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
      dram_re    <= 1'b0;
      dram_we    <= 1'b0;
      dram_addr  <= '0;
      dram_din   <= '0;
      dout_q     <= '0;
      vic_q      <= '0;
      used_inv_q <= 1'b0;
    end else begin
      unique case (1'b1)
        complete: begin
          if (we) begin
            data_q[hit_way][idx][{off, 5'b0} +: 32] <= din;
            dirty_q[hit_way][idx] <= 1'b1;
          end
          if (re) dout_q <= hit_word;
        end
        miss: begin
          vic_q      <= victim;
          used_inv_q <= inv;
          if (vic_dirty) begin
            dram_we   <= 1'b1;
            dram_addr <= {tag_q[victim][idx], idx};
            dram_din  <= data_q[victim][idx];
          end else begin
            dram_re   <= 1'b1;
            dram_addr <= {req_tag, idx};
          end
        end
        (state_q == WB && dram_complete): begin
          dram_we               <= 1'b0;
          dirty_q[vic_q][idx]   <= 1'b0;
          dram_re               <= 1'b1;
          dram_addr             <= {req_tag, idx};
        end
        (state_q == FILL && dram_complete): begin
          dram_re             <= 1'b0;
          data_q[vic_q][idx]  <= dram_dout;
          tag_q[vic_q][idx]   <= req_tag;
          valid_q[vic_q][idx] <= 1'b1;
          dirty_q[vic_q][idx] <= 1'b0;
          if (!used_inv_q)
            ptr_q[idx] <= (WAYS > 1) ? vic_q + 1'b1 : '0;
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      hit_cnt  <= hit_cnt + 32'(complete);
      miss_cnt <= miss_cnt + 32'(miss);
      wb_cnt   <= wb_cnt + 32'(state_q == WB && dram_complete);
    end
  end
`endif

endmodule

// File: tb/tb_cache_assoc.sv
// Self-checking bench for cache_assoc with a latency DRAM model.
// Define CACHE_STATS_EN to also check the counters.
module tb_cache_assoc;

  localparam int LAT   = 3;
  localparam int BOUND = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  addr = '0;
  logic         re = 1'b0;
  logic         we = 1'b0;
  logic [31:0]  din = '0;
  logic [31:0]  dout;
  logic         complete;
  logic         dram_re;
  logic         dram_we;
  logic [27:0]  dram_addr;
  logic [127:0] dram_din;
  logic [127:0] dram_dout = '0;
  logic         dram_complete = 1'b0;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int both_err = 0;

  always #5 clk = ~clk;

  cache_assoc dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .re            (re),
    .we            (we),
    .din           (din),
    .dout          (dout),
    .complete      (complete),
    .dram_re       (dram_re),
    .dram_we       (dram_we),
    .dram_addr     (dram_addr),
    .dram_din      (dram_din),
    .dram_dout     (dram_dout),
    .dram_complete (dram_complete)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt),
    .wb_cnt        (wb_cnt)
`endif
  );

  function automatic logic [31:0] pw(input int ba, input int i);
    return 32'hA500_0000 + 32'(ba) * 32'd16 + 32'(i);
  endfunction

  function automatic logic [127:0] pat(input int ba);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[32*i +: 32] = pw(ba, i);
    return b;
  endfunction

  logic [127:0] mem [int];
  bit           ev_q[$];
  int           wb_addr_q[$];
  logic [127:0] wb_data_q[$];
  int           rd_addr_q[$];
  logic [31:0]  exp_q[$];
  bit           busy = 1'b0;
  int           lat = 0;

  // DRAM: a new request is seen one cycle after it rises, done LAT cycles later.
  always @(posedge clk) begin
    if (!rst) begin
      dram_complete <= 1'b0;
      busy <= 1'b0;
      lat <= 0;
    end else if (dram_complete) begin
      dram_complete <= 1'b0;
    end else if (dram_re || dram_we) begin
      if (!busy) begin
        busy <= 1'b1;
        lat <= 1;
        ev_q.push_back(dram_we);
      end else if (lat == LAT - 1) begin
        dram_complete <= 1'b1;
        busy <= 1'b0;
        if (dram_we) begin
          mem[int'(dram_addr)] = dram_din;
          wb_addr_q.push_back(int'(dram_addr));
          wb_data_q.push_back(dram_din);
        end else begin
          rd_addr_q.push_back(int'(dram_addr));
          dram_dout <= mem.exists(int'(dram_addr)) ?
                       mem[int'(dram_addr)] : pat(int'(dram_addr));
        end
      end else begin
        lat <= lat + 1;
      end
    end else begin
      busy <= 1'b0;
    end
  end

  always @(negedge clk)
    if (rst && dram_re && dram_we) both_err++;

  a_req_stable: assert property (@(posedge clk) disable iff (!rst)
    ((re | we) && !complete) |=> ((re | we) && $stable(addr)))
    else $error("request changed before complete");

  task automatic access(input logic [31:0] a, input logic w,
                        input logic [31:0] d, output int cyc);
    logic [31:0] e;
    @(negedge clk);
    addr = a; din = d; re = !w; we = w;
    cyc = 0;
    #1;
    while (!complete && cyc < BOUND) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (!complete) begin
      tests++; fails++;
      $display("FAIL timeout addr=%h: no complete in %0d cycles", a, BOUND);
      if (!w && exp_q.size() > 0) e = exp_q.pop_front();
    end else if (!w) begin
      e = exp_q.pop_front();
      tests++;
      if (dout !== e) begin
        fails++;
        $display("FAIL rd_%h: dout=%h expected=%h", a, dout, e);
      end
    end
    @(posedge clk);
    #1;
    re = 1'b0; we = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_complete", 128'(complete), 128'd0);
    chk("rst_dram_re", 128'(dram_re), 128'd0);
    chk("rst_dram_we", 128'(dram_we), 128'd0);
    chk("rst_dram_addr", 128'(dram_addr), 128'd0);
    chk("rst_dram_din", dram_din, 128'd0);
    chk("rst_dout", 128'(dout), 128'd0);
`ifdef CACHE_STATS_EN
    chk("rst_stats", {32'd0, hit_cnt, miss_cnt, wb_cnt}, 128'd0);
`endif
  endtask

  task automatic test_cold_read();
    int cyc, n0, r0;
    n0 = ev_q.size();
    r0 = rd_addr_q.size();
    exp_q.push_back(pw(4, 0));
    access(32'h40, 1'b0, '0, cyc);
    chk("cold_is_miss", 128'(cyc > 0), 128'd1);
    chk("cold_one_read", 128'(ev_q.size() == n0 + 1 && ev_q[n0] == 1'b0), 128'd1);
    chk("cold_fill_addr", 128'(rd_addr_q.size() > r0 ? rd_addr_q[r0] : -1), 128'(4));
    n0 = ev_q.size();
    exp_q.push_back(pw(4, 0));
    access(32'h40, 1'b0, '0, cyc);
    chk("reread_zero_wait", 128'(cyc), 128'd0);
    chk("reread_no_dram", 128'(ev_q.size()), 128'(n0));
    @(negedge clk);
    chk("idle_no_complete", 128'(complete), 128'd0);
    chk("idle_dout_held", 128'(dout), 128'(pw(4, 0)));
  endtask

  task automatic test_write_hit();
    int cyc, n0;
    n0 = ev_q.size();
    access(32'h44, 1'b1, 32'hDEADBEEF, cyc);
    chk("wr_zero_wait", 128'(cyc), 128'd0);
    chk("wr_no_dram", 128'(ev_q.size()), 128'(n0));
    exp_q.push_back(32'hDEADBEEF);
    access(32'h44, 1'b0, '0, cyc);
    chk("wr_readback_hit", 128'(cyc), 128'd0);
  endtask

  task automatic test_writeback();
    int cyc, n0, w0;
    n0 = ev_q.size();
    exp_q.push_back(pw(36, 0));
    access(32'h240, 1'b0, '0, cyc);
    chk("tag1_fill_only", 128'(ev_q.size() == n0 + 1 && ev_q[n0] == 1'b0), 128'd1);
    n0 = ev_q.size();
    w0 = wb_addr_q.size();
    exp_q.push_back(pw(68, 0));
    access(32'h440, 1'b0, '0, cyc);
    chk("tag2_wb_then_fill",
        128'(ev_q.size() == n0 + 2 && ev_q[n0] == 1'b1 && ev_q[n0+1] == 1'b0), 128'd1);
    if (wb_addr_q.size() > w0) begin
      chk("wb_addr", 128'(wb_addr_q[w0]), 128'(4));
      chk("wb_word1", 128'(wb_data_q[w0][63:32]), 128'(32'hDEADBEEF));
      chk("wb_word0", 128'(wb_data_q[w0][31:0]), 128'(pw(4, 0)));
    end else begin
      tests++; fails++;
      $display("FAIL wb_missing: writebacks=%0d expected=%0d", wb_addr_q.size(), w0 + 1);
    end
    exp_q.push_back(pw(36, 1));
    access(32'h244, 1'b0, '0, cyc);
    chk("way1_kept_hit", 128'(cyc), 128'd0);
  endtask

  task automatic test_clean_conflict();
    int cyc, n0;
    n0 = ev_q.size();
    exp_q.push_back(pw(100, 0));
    access(32'h640, 1'b0, '0, cyc);
    chk("clean_fill_only", 128'(ev_q.size() == n0 + 1 && ev_q[n0] == 1'b0), 128'd1);
    exp_q.push_back(pw(68, 1));
    access(32'h444, 1'b0, '0, cyc);
    chk("way0_kept_hit", 128'(cyc), 128'd0);
`ifdef CACHE_STATS_EN
    @(negedge clk);
    chk("hit_cnt", 128'(hit_cnt), 128'd9);
    chk("miss_cnt", 128'(miss_cnt), 128'd4);
    chk("wb_cnt", 128'(wb_cnt), 128'd1);
`endif
  endtask

  task automatic test_reset_mid_wb();
    int cyc, k, n0;
    access(32'h440, 1'b1, 32'h1234_5678, cyc);
    chk("dirty_way0_hit", 128'(cyc), 128'd0);
    @(negedge clk);
    addr = 32'h840; re = 1'b1;
    k = 0;
    while (!dram_we && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("mid_wb_reached", 128'(dram_we), 128'd1);
    rst = 1'b0; re = 1'b0;
    @(negedge clk);
    chk("mid_wb_dram_we", 128'(dram_we), 128'd0);
    chk("mid_wb_dram_re", 128'(dram_re), 128'd0);
    chk("mid_wb_dram_addr", 128'(dram_addr), 128'd0);
`ifdef CACHE_STATS_EN
    chk("mid_wb_stats", {32'd0, hit_cnt, miss_cnt, wb_cnt}, 128'd0);
`endif
    rst = 1'b1;
    n0 = ev_q.size();
    exp_q.push_back(pw(4, 0));
    access(32'h40, 1'b0, '0, cyc);
    chk("post_rst_miss", 128'(cyc > 0 && ev_q.size() == n0 + 1), 128'd1);
    exp_q.push_back(32'hDEADBEEF);
    access(32'h44, 1'b0, '0, cyc);
    chk("wb_data_refetched", 128'(cyc), 128'd0);
  endtask

  task automatic test_exclusive();
    chk("re_we_exclusive", 128'(both_err), 128'd0);
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit();
    test_writeback();
    test_clean_conflict();
    test_reset_mid_wb();
    test_exclusive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
